glb_crd_rsp: RTL and testbench
==============================

# glb_crd_rsp

Responder for the coordinate-fetch port of the global buffer: accepts coordinate read addresses from the controller's FPS/KNN engines and issues reads to a fixed-latency SRAM bank. It returns the read words in request order through a valid/ready channel, and absorbs consumer back-pressure with a credit-limited output FIFO. It sits inside GLB between the CTR-facing crd port and one SRAM bank. It is configured per layer by CCU with a base address and word count.

## Interface
- SRAM_WIDTH, 256, data word width
- IDX_WIDTH, 10, width of requested (logical) coordinate address
- ADDR_WIDTH, 12, SRAM physical address width
- RD_LAT, 2, SRAM read latency in cycles (1..3)
- OUT_DEPTH, 4, output FIFO depth (≥ RD_LAT+1 for full throughput)

Ports:
- clk  in  1  clock
- rst_n  in  1  reset; asynchronous, active-low (one clock, async active-low reset)
- CCUGLB_Rst  in  1  synchronous soft clear
- CCUGLB_CfgVld  in  1  config valid
- GLBCCU_CfgRdy  out  1  config ready (high only in IDLE)
- CCUGLB_CfgBase  in  ADDR_WIDTH  physical base of coordinate region
- CCUGLB_CfgNum  in  IDX_WIDTH  number of words to serve this layer
- CTRGLB_CrdAddr  in  IDX_WIDTH  logical read address
- CTRGLB_CrdAddrVld  in  1  address valid
- GLBCTR_CrdAddrRdy  out  1  address ready
- GLBCTR_Crd  out  SRAM_WIDTH  read data
- GLBCTR_CrdVld  out  1  data valid
- CTRGLB_CrdRdy  in  1  data ready
- GLBSRAM_RdEn  out  1  SRAM read enable
- GLBSRAM_RdAddr  out  ADDR_WIDTH  SRAM read address
- SRAMGLB_RdDat  in  SRAM_WIDTH  SRAM read data, valid RD_LAT cycles after RdEn
- GLBCCU_AddrErr  out  1  sticky out-of-range flag, cleared on config accept

## Operation
- States: IDLE, BUSY.
  - IDLE: CfgRdy=1. On CfgVld, latch Base/Num, clear counters and AddrErr.
    - Num≠0 → BUSY.
    - Num=0 → stay IDLE.
  - BUSY: CfgRdy=0. → IDLE in the cycle the Num-th response handshakes.
- Address accept (fire = Vld&Rdy).
  - AddrRdy = BUSY & (acc_cnt < Num) & (inflight + fifo_cnt < OUT_DEPTH).
  - The credit check counts inflight SRAM reads plus stored FIFO entries, so read data always has a slot. The SRAM has no stall.
- On fire with CrdAddr < Num: RdEn=1, RdAddr = (Base + CrdAddr) mod 2^ADDR_WIDTH, which wraps silently.
- On fire with CrdAddr ≥ Num: no SRAM read. Set AddrErr. An all-zero word is returned in its ordered slot.
- Ordering: a RD_LAT-deep shift pipeline carries {valid, err} per accepted request. At the tail, the FIFO pushes SRAMGLB_RdDat, or zero if err.
- FIFO: OUT_DEPTH entries, circular pointers with wrap. Simultaneous push and pop leaves the count unchanged. CrdVld = fifo_cnt≠0, Crd = head entry.
- acc_cnt counts address fires; rsp_cnt counts data fires. Both are IDX_WIDTH+1 bits so they never overflow at Num.
- CCUGLB_Rst clears pipeline, FIFO, counters and AddrErr, and forces IDLE next cycle. Inflight SRAM data is discarded. If it coincides with CfgVld, Rst wins.

## Timing
- Reset values (async): all outputs 0 except GLBCCU_CfgRdy=1. State=IDLE.
- GLBCTR_CrdAddrRdy, GLBCTR_CrdVld and GLBCTR_Crd are registered-state-derived, with no combinational path from CTRGLB_CrdRdy or CTRGLB_CrdAddrVld.
- GLBSRAM_RdEn and GLBSRAM_RdAddr are combinational from the address fire.
- Latency: address fire in cycle t → CrdVld in cycle t+RD_LAT+1 when the FIFO is empty. Sustained throughput is 1 word/cycle with CrdRdy=1 and OUT_DEPTH ≥ RD_LAT+1.
- Handshakes: once CrdVld is high, the data holds until it handshakes. AddrRdy may drop without a handshake.
- With CrdRdy stuck low, at most OUT_DEPTH addresses are accepted. AddrRdy stays 0 until a pop frees a credit, and goes high the cycle after that pop.

## Test plan
1. Back-to-back stream, Base=0x100, Num=8, addresses 0..7, CrdRdy=1 → SRAM reads 0x100..0x107 on consecutive cycles. First CrdVld is 3 cycles after the first fire. 8 words arrive in order, then CfgRdy=1.
2. Back-pressure, Num=8, CrdRdy=0 for 20 cycles then 1 → exactly 4 addresses accepted and AddrRdy=0 during the stall. All 8 words are then delivered in order with no loss or duplication.
3. Wrap, Base=0xFFE, Num=4, addresses 0..3 → RdAddr 0xFFE, 0xFFF, 0x000, 0x001.
4. Out-of-range, Num=4, addresses 1, 7, 2 → reads issued for 1 and 2 only. Responses are data(1), 0, data(2). AddrErr=1 until the next config accept.
5. Soft clear mid-burst, Num=8, CCUGLB_Rst asserted after 3 address fires with data inflight → next cycle CrdVld=0, CfgRdy=1. A new config with Num=2 returns exactly 2 correct words.
6. Num=0 config → CfgRdy stays 1, AddrRdy never asserts, no RdEn.

Source files
------------

// File: rtl/glb_crd_rsp.sv
// glb_crd_rsp
//   Coordinate-fetch responder for one global-buffer SRAM bank.
//
//   The controller issues logical coordinate addresses. Each accepted address
//   becomes a read of the fixed-latency SRAM at (base + addr). The read words
//   return in request order on a valid/ready channel. An output FIFO absorbs
//   consumer back-pressure. Addresses are accepted only while a FIFO slot is
//   guaranteed for the data, because the SRAM cannot be stalled.
//
//   Ports
//     clk, rst_n          clock, async active-low reset
//     CCUGLB_Rst          synchronous soft clear (wins over config)
//     CCUGLB_CfgVld/Rdy   per-layer config handshake (ready only in IDLE)
//     CCUGLB_CfgBase/Num  physical base and word count for the layer
//     CTRGLB_CrdAddr*     logical address request channel
//     GLBCTR_Crd*         read data response channel
//     GLBSRAM_Rd*         SRAM read enable/address (combinational from fire)
//     SRAMGLB_RdDat       SRAM data, valid RD_LAT cycles after RdEn
//     GLBCCU_AddrErr      sticky out-of-range flag
module glb_crd_rsp #(
    parameter int SRAM_WIDTH = 256,
    parameter int IDX_WIDTH  = 10,
    parameter int ADDR_WIDTH = 12,
    parameter int RD_LAT     = 2,
    parameter int OUT_DEPTH  = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  CCUGLB_Rst,
    input  logic                  CCUGLB_CfgVld,
    output logic                  GLBCCU_CfgRdy,
    input  logic [ADDR_WIDTH-1:0] CCUGLB_CfgBase,
    input  logic [IDX_WIDTH-1:0]  CCUGLB_CfgNum,
    input  logic [IDX_WIDTH-1:0]  CTRGLB_CrdAddr,
    input  logic                  CTRGLB_CrdAddrVld,
    output logic                  GLBCTR_CrdAddrRdy,
    output logic [SRAM_WIDTH-1:0] GLBCTR_Crd,
    output logic                  GLBCTR_CrdVld,
    input  logic                  CTRGLB_CrdRdy,
    output logic                  GLBSRAM_RdEn,
    output logic [ADDR_WIDTH-1:0] GLBSRAM_RdAddr,
    input  logic [SRAM_WIDTH-1:0] SRAMGLB_RdDat,
    output logic                  GLBCCU_AddrErr
);

    localparam int CW = $clog2(OUT_DEPTH + 1);
    localparam int PW = (OUT_DEPTH > 1) ? $clog2(OUT_DEPTH) : 1;

    typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

    state_t                 r_state, w_state_nxt;
    logic [ADDR_WIDTH-1:0]  r_base;
    logic [IDX_WIDTH-1:0]   r_num;
    logic [IDX_WIDTH:0]     r_acc_cnt;
    logic [IDX_WIDTH:0]     r_rsp_cnt;
    logic                   r_err;

    // One {valid, err} slot per SRAM latency cycle; the tail lines up with RdDat.
    logic [RD_LAT-1:0]      r_vld_pipe;
    logic [RD_LAT-1:0]      r_err_pipe;
    logic [CW-1:0]          r_infl;

    logic [SRAM_WIDTH-1:0]  r_mem [OUT_DEPTH];
    logic [PW-1:0]          r_wp, r_rp;
    logic [CW-1:0]          r_fifo_cnt;

    logic                   w_busy;
    logic [CW:0]            w_credit;
    logic                   w_addr_rdy;
    logic                   w_addr_fire;
    logic                   w_oor;
    logic                   w_push;
    logic [SRAM_WIDTH-1:0]  w_push_dat;
    logic                   w_crd_vld;
    logic                   w_pop;
    logic                   w_last_rsp;
    logic                   w_cfg_acc;
    logic [ADDR_WIDTH-1:0]  w_phys;

    assign w_busy      = (r_state == BUSY);
    // Credits cover reads still in the SRAM as well as stored words.
    assign w_credit    = (CW+1)'(r_infl) + (CW+1)'(r_fifo_cnt);
    assign w_addr_rdy  = w_busy && (r_acc_cnt < {1'b0, r_num}) &&
                         (w_credit < (CW+1)'(OUT_DEPTH));
    assign w_addr_fire = CTRGLB_CrdAddrVld & w_addr_rdy;
    assign w_oor       = (CTRGLB_CrdAddr >= r_num);
    assign w_phys      = r_base + ADDR_WIDTH'(CTRGLB_CrdAddr);

    assign w_push      = r_vld_pipe[RD_LAT-1];
    assign w_push_dat  = r_err_pipe[RD_LAT-1] ? '0 : SRAMGLB_RdDat;
    assign w_crd_vld   = (r_fifo_cnt != '0);
    assign w_pop       = w_crd_vld & CTRGLB_CrdRdy;
    assign w_last_rsp  = w_pop && ((r_rsp_cnt + (IDX_WIDTH+1)'(1)) == {1'b0, r_num});
    assign w_cfg_acc   = (r_state == IDLE) & CCUGLB_CfgVld & ~CCUGLB_Rst;

    assign GLBCCU_CfgRdy     = (r_state == IDLE);
    assign GLBCTR_CrdAddrRdy = w_addr_rdy;
    assign GLBCTR_CrdVld     = w_crd_vld;
    assign GLBCTR_Crd        = w_crd_vld ? r_mem[r_rp] : '0;
    assign GLBSRAM_RdEn      = w_addr_fire & ~w_oor;
    assign GLBSRAM_RdAddr    = (w_addr_fire & ~w_oor) ? w_phys : '0;
    assign GLBCCU_AddrErr    = r_err;

    // ---------------- FSM ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_cfg_acc && (CCUGLB_CfgNum != '0)) w_state_nxt = BUSY;
            BUSY:    if (w_last_rsp) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
        if (CCUGLB_Rst) w_state_nxt = IDLE;
    end

    // ---------------- config / counters / error ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_base <= '0;
            r_num  <= '0;
        end else if (w_cfg_acc) begin
            r_base <= CCUGLB_CfgBase;
            r_num  <= CCUGLB_CfgNum;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc_cnt <= '0;
            r_rsp_cnt <= '0;
            r_err     <= 1'b0;
        end else if (CCUGLB_Rst || w_cfg_acc) begin
            r_acc_cnt <= '0;
            r_rsp_cnt <= '0;
            r_err     <= 1'b0;
        end else begin
            if (w_addr_fire)          r_acc_cnt <= r_acc_cnt + (IDX_WIDTH+1)'(1);
            if (w_pop)                r_rsp_cnt <= r_rsp_cnt + (IDX_WIDTH+1)'(1);
            if (w_addr_fire && w_oor) r_err     <= 1'b1;
        end
    end

    // ---------------- ordering pipeline ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vld_pipe <= '0;
            r_err_pipe <= '0;
            r_infl     <= '0;
        end else if (CCUGLB_Rst) begin
            // Data still inside the SRAM is dropped: its tags vanish here.
            r_vld_pipe <= '0;
            r_err_pipe <= '0;
            r_infl     <= '0;
        end else begin
            for (int i = RD_LAT - 1; i > 0; i--) begin
                r_vld_pipe[i] <= r_vld_pipe[i-1];
                r_err_pipe[i] <= r_err_pipe[i-1];
            end
            r_vld_pipe[0] <= w_addr_fire;
            r_err_pipe[0] <= w_addr_fire & w_oor;
            r_infl        <= r_infl + CW'(w_addr_fire) - CW'(w_push);
        end
    end

    // ---------------- output FIFO ----------------
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wp] <= w_push_dat;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wp       <= '0;
            r_rp       <= '0;
            r_fifo_cnt <= '0;
        end else if (CCUGLB_Rst) begin
            r_wp       <= '0;
            r_rp       <= '0;
            r_fifo_cnt <= '0;
        end else begin
            if (w_push) r_wp <= (r_wp == PW'(OUT_DEPTH - 1)) ? '0 : r_wp + PW'(1);
            if (w_pop)  r_rp <= (r_rp == PW'(OUT_DEPTH - 1)) ? '0 : r_rp + PW'(1);
            case ({w_push, w_pop})
                2'b10:   r_fifo_cnt <= r_fifo_cnt + CW'(1);
                2'b01:   r_fifo_cnt <= r_fifo_cnt - CW'(1);
                default: r_fifo_cnt <= r_fifo_cnt;
            endcase
        end
    end

endmodule

// File: tb/tb_glb_crd_rsp.sv
// Bench for glb_crd_rsp: SRAM model with fixed latency, a passive monitor
// that logs handshakes, and per-scenario tasks that compare the logs with
// expectations computed from base/num/address lists.
module tb_glb_crd_rsp;
    localparam int SW = 256, IW = 10, AW = 12, RD_LAT = 2, OUT_DEPTH = 4;

    typedef logic [IW-1:0] a_q_t[$];

    logic          clk = 1'b0, rst_n = 1'b0;
    logic          CCUGLB_Rst = 0, CCUGLB_CfgVld = 0, GLBCCU_CfgRdy;
    logic [AW-1:0] CCUGLB_CfgBase = '0;
    logic [IW-1:0] CCUGLB_CfgNum = '0, CTRGLB_CrdAddr = '0;
    logic          CTRGLB_CrdAddrVld = 0, GLBCTR_CrdAddrRdy;
    logic [SW-1:0] GLBCTR_Crd, SRAMGLB_RdDat;
    logic          GLBCTR_CrdVld, CTRGLB_CrdRdy = 0;
    logic          GLBSRAM_RdEn, GLBCCU_AddrErr;
    logic [AW-1:0] GLBSRAM_RdAddr;

    int total = 0, bad = 0;

    glb_crd_rsp #(.SRAM_WIDTH(SW), .IDX_WIDTH(IW), .ADDR_WIDTH(AW),
                  .RD_LAT(RD_LAT), .OUT_DEPTH(OUT_DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .CCUGLB_Rst(CCUGLB_Rst),
        .CCUGLB_CfgVld(CCUGLB_CfgVld), .GLBCCU_CfgRdy(GLBCCU_CfgRdy),
        .CCUGLB_CfgBase(CCUGLB_CfgBase), .CCUGLB_CfgNum(CCUGLB_CfgNum),
        .CTRGLB_CrdAddr(CTRGLB_CrdAddr), .CTRGLB_CrdAddrVld(CTRGLB_CrdAddrVld),
        .GLBCTR_CrdAddrRdy(GLBCTR_CrdAddrRdy), .GLBCTR_Crd(GLBCTR_Crd),
        .GLBCTR_CrdVld(GLBCTR_CrdVld), .CTRGLB_CrdRdy(CTRGLB_CrdRdy),
        .GLBSRAM_RdEn(GLBSRAM_RdEn), .GLBSRAM_RdAddr(GLBSRAM_RdAddr),
        .SRAMGLB_RdDat(SRAMGLB_RdDat), .GLBCCU_AddrErr(GLBCCU_AddrErr));

    always #5 clk = ~clk;

    // SRAM content is a fixed, never-zero function of the physical address.
    function automatic logic [SW-1:0] mkword(input logic [AW-1:0] a);
        logic [SW-1:0] w;
        for (int k = 0; k < 8; k++)
            w[k*32 +: 32] = {20'h0, a} * 32'h0100_0193 + 32'(k) * 32'h1111 + 32'h1;
        return w;
    endfunction

    logic [AW-1:0] sr_a [RD_LAT];
    always @(posedge clk) begin
        sr_a[0] <= GLBSRAM_RdAddr;
        for (int i = 1; i < RD_LAT; i++) sr_a[i] <= sr_a[i-1];
    end
    assign SRAMGLB_RdDat = mkword(sr_a[RD_LAT-1]);

    // Monitor: logs what crossed each channel and when.
    int            cyc = 0, first_vld_cyc = -1;
    logic [IW-1:0] acc_q[$];
    int            acc_cyc_q[$];
    logic [AW-1:0] rd_q[$];
    int            rd_cyc_q[$];
    logic [SW-1:0] dat_q[$];

    always @(posedge clk) begin
        if (rst_n) begin
            if (CTRGLB_CrdAddrVld && GLBCTR_CrdAddrRdy) begin
                acc_q.push_back(CTRGLB_CrdAddr); acc_cyc_q.push_back(cyc);
            end
            if (GLBSRAM_RdEn) begin
                rd_q.push_back(GLBSRAM_RdAddr); rd_cyc_q.push_back(cyc);
            end
            if (GLBCTR_CrdVld && CTRGLB_CrdRdy) dat_q.push_back(GLBCTR_Crd);
            if (GLBCTR_CrdVld && first_vld_cyc < 0) first_vld_cyc = cyc;
            cyc++;
        end
    end

    task automatic clear_mon();
        acc_q.delete(); acc_cyc_q.delete(); rd_q.delete(); rd_cyc_q.delete();
        dat_q.delete(); first_vld_cyc = -1;
    endtask

    // All driving happens on the falling edge.
    task automatic cfg(input logic [AW-1:0] base, input logic [IW-1:0] num);
        CCUGLB_CfgVld = 1; CCUGLB_CfgBase = base; CCUGLB_CfgNum = num;
        @(posedge clk); @(negedge clk);
        CCUGLB_CfgVld = 0;
    endtask

    task automatic idle(input int n, input logic rdy);
        CTRGLB_CrdRdy = rdy;
        repeat (n) @(negedge clk);
        CTRGLB_CrdRdy = 0;
    endtask

    // Offers addrs in order (valid held until accepted) until nresp words
    // have been received or the cycle budget runs out.
    task automatic run_stream(input a_q_t addrs, input int nresp,
                              input int vld_pct, input int rdy_pct, input int budget);
        int  idx = 0, n = 0;
        logic fire;
        while (dat_q.size() < nresp && n < budget) begin
            if (!CTRGLB_CrdAddrVld && idx < addrs.size() && $urandom_range(99) < vld_pct) begin
                CTRGLB_CrdAddrVld = 1; CTRGLB_CrdAddr = addrs[idx];
            end
            CTRGLB_CrdRdy = ($urandom_range(99) < rdy_pct);
            #1 fire = CTRGLB_CrdAddrVld && GLBCTR_CrdAddrRdy;
            @(posedge clk); @(negedge clk);
            if (fire) begin idx++; CTRGLB_CrdAddrVld = 0; end
            n++;
        end
        CTRGLB_CrdAddrVld = 0; CTRGLB_CrdRdy = 0;
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        total++; if (GLBCCU_CfgRdy !== 1'b1) begin bad++; $display("FAIL rst_cfgrdy got=%0b exp=1", GLBCCU_CfgRdy); end
        total++; if ({GLBCTR_CrdAddrRdy, GLBCTR_CrdVld, GLBSRAM_RdEn, GLBCCU_AddrErr} !== 4'b0) begin
            bad++; $display("FAIL rst_flags got=%b exp=0000", {GLBCTR_CrdAddrRdy, GLBCTR_CrdVld, GLBSRAM_RdEn, GLBCCU_AddrErr}); end
        total++; if (GLBCTR_Crd !== '0 || GLBSRAM_RdAddr !== '0) begin
            bad++; $display("FAIL rst_data got=%0h/%0h exp=0/0", GLBCTR_Crd, GLBSRAM_RdAddr); end
        rst_n = 1;
        @(negedge clk);
    endtask

    task automatic test_stream();
        a_q_t a = {};
        for (int i = 0; i < 8; i++) a.push_back(IW'(i));
        cfg(12'h100, 8); clear_mon();
        run_stream(a, 8, 100, 100, 200);
        total++; if (dat_q.size() != 8) begin bad++; $display("FAIL stream_cnt got=%0d exp=8", dat_q.size()); end
        for (int i = 0; i < 8; i++) begin
            logic [SW-1:0] got = (i < dat_q.size()) ? dat_q[i] : 'x;
            logic [AW-1:0] ra  = (i < rd_q.size()) ? rd_q[i] : 'x;
            total++; if (got !== mkword(AW'(12'h100 + i))) begin bad++; $display("FAIL stream_dat[%0d] got=%0h exp=%0h", i, got, mkword(AW'(12'h100 + i))); end
            total++; if (ra !== AW'(12'h100 + i)) begin bad++; $display("FAIL stream_rdaddr[%0d] got=%0h exp=%0h", i, ra, 12'h100 + i); end
        end
        total++; if (rd_cyc_q.size() != 8 || rd_cyc_q[7] - rd_cyc_q[0] != 7) begin
            bad++; $display("FAIL stream_b2b got=%0d reads exp=8 consecutive", rd_cyc_q.size()); end
        total++; if (acc_cyc_q.size() == 0 || first_vld_cyc - acc_cyc_q[0] != RD_LAT + 1) begin
            bad++; $display("FAIL stream_latency got=%0d exp=%0d", first_vld_cyc - (acc_cyc_q.size() ? acc_cyc_q[0] : 0), RD_LAT + 1); end
        total++; if (GLBCCU_CfgRdy !== 1'b1) begin bad++; $display("FAIL stream_done got=%0b exp=1", GLBCCU_CfgRdy); end
    endtask

    task automatic test_backpressure();
        a_q_t a = {}, rem = {};
        for (int i = 0; i < 8; i++) a.push_back(IW'(i));
        cfg(12'h200, 8); clear_mon();
        run_stream(a, 8, 100, 0, 20);
        total++; if (acc_q.size() != OUT_DEPTH) begin bad++; $display("FAIL bp_accepted got=%0d exp=%0d", acc_q.size(), OUT_DEPTH); end
        total++; if (GLBCTR_CrdAddrRdy !== 1'b0) begin bad++; $display("FAIL bp_rdy_stall got=%0b exp=0", GLBCTR_CrdAddrRdy); end
        // One pop frees exactly one credit, visible the next cycle.
        CTRGLB_CrdRdy = 1; @(posedge clk); @(negedge clk); CTRGLB_CrdRdy = 0;
        total++; if (GLBCTR_CrdAddrRdy !== 1'b1) begin bad++; $display("FAIL bp_rdy_after_pop got=%0b exp=1", GLBCTR_CrdAddrRdy); end
        for (int i = acc_q.size(); i < 8; i++) rem.push_back(IW'(i));
        run_stream(rem, 8, 100, 100, 200);
        idle(4, 1'b1);
        total++; if (dat_q.size() != 8) begin bad++; $display("FAIL bp_cnt got=%0d exp=8", dat_q.size()); end
        for (int i = 0; i < 8; i++) begin
            logic [SW-1:0] got = (i < dat_q.size()) ? dat_q[i] : 'x;
            total++; if (got !== mkword(AW'(12'h200 + i))) begin bad++; $display("FAIL bp_dat[%0d] got=%0h exp=%0h", i, got, mkword(AW'(12'h200 + i))); end
        end
    endtask

    task automatic test_wrap();
        logic [AW-1:0] exp_a [4] = '{12'hFFE, 12'hFFF, 12'h000, 12'h001};
        a_q_t a = {10'd0, 10'd1, 10'd2, 10'd3};
        cfg(12'hFFE, 4); clear_mon();
        run_stream(a, 4, 100, 100, 100);
        for (int i = 0; i < 4; i++) begin
            logic [AW-1:0] ra  = (i < rd_q.size()) ? rd_q[i] : 'x;
            logic [SW-1:0] got = (i < dat_q.size()) ? dat_q[i] : 'x;
            total++; if (ra !== exp_a[i]) begin bad++; $display("FAIL wrap_rdaddr[%0d] got=%0h exp=%0h", i, ra, exp_a[i]); end
            total++; if (got !== mkword(exp_a[i])) begin bad++; $display("FAIL wrap_dat[%0d] got=%0h exp=%0h", i, got, mkword(exp_a[i])); end
        end
    endtask

    task automatic test_out_of_range();
        a_q_t a = {10'd1, 10'd7, 10'd2};
        logic [SW-1:0] exp_d [3];
        exp_d[0] = mkword(12'h041); exp_d[1] = '0; exp_d[2] = mkword(12'h042);
        cfg(12'h040, 4); clear_mon();
        run_stream(a, 3, 100, 100, 100);
        total++; if (rd_q.size() != 2 || rd_q[0] !== 12'h041 || rd_q[1] !== 12'h042) begin
            bad++; $display("FAIL oor_reads got=%0d reads exp=2 (041,042)", rd_q.size()); end
        for (int i = 0; i < 3; i++) begin
            logic [SW-1:0] got = (i < dat_q.size()) ? dat_q[i] : 'x;
            total++; if (got !== exp_d[i]) begin bad++; $display("FAIL oor_dat[%0d] got=%0h exp=%0h", i, got, exp_d[i]); end
        end
        total++; if (GLBCCU_AddrErr !== 1'b1) begin bad++; $display("FAIL oor_err got=%0b exp=1", GLBCCU_AddrErr); end
        a = {10'd3};
        run_stream(a, 4, 100, 100, 100);
        total++; if (GLBCCU_AddrErr !== 1'b1 || GLBCCU_CfgRdy !== 1'b1) begin
            bad++; $display("FAIL oor_sticky got=err%0b/cfgrdy%0b exp=1/1", GLBCCU_AddrErr, GLBCCU_CfgRdy); end
    endtask

    task automatic test_soft_clear();
        a_q_t a = {10'd0, 10'd1, 10'd2};
        cfg(12'h300, 8);
        total++; if (GLBCCU_AddrErr !== 1'b0) begin bad++; $display("FAIL clr_err_on_cfg got=%0b exp=0", GLBCCU_AddrErr); end
        clear_mon();
        run_stream(a, 99, 100, 0, 3);
        CCUGLB_Rst = 1; @(posedge clk); @(negedge clk); CCUGLB_Rst = 0;
        total++; if (GLBCTR_CrdVld !== 1'b0 || GLBCCU_CfgRdy !== 1'b1 || GLBCTR_CrdAddrRdy !== 1'b0) begin
            bad++; $display("FAIL clr_state got=vld%0b/cfgrdy%0b/ardy%0b exp=0/1/0", GLBCTR_CrdVld, GLBCCU_CfgRdy, GLBCTR_CrdAddrRdy); end
        idle(5, 1'b1);
        total++; if (dat_q.size() != 0 || GLBCTR_CrdVld !== 1'b0) begin
            bad++; $display("FAIL clr_discard got=%0d words exp=0", dat_q.size()); end
        cfg(12'h500, 2); clear_mon();
        a = {10'd1, 10'd0};
        run_stream(a, 2, 100, 100, 100);
        idle(5, 1'b1);
        total++; if (dat_q.size() != 2) begin bad++; $display("FAIL clr_new_cnt got=%0d exp=2", dat_q.size()); end
        total++; if (dat_q.size() < 2 || dat_q[0] !== mkword(12'h501) || dat_q[1] !== mkword(12'h500)) begin
            bad++; $display("FAIL clr_new_dat got=%0h exp=%0h", dat_q.size() ? dat_q[0] : '0, mkword(12'h501)); end
    endtask

    task automatic test_num_zero();
        int rdy_seen = 0;
        cfg(12'h100, 0); clear_mon();
        total++; if (GLBCCU_CfgRdy !== 1'b1) begin bad++; $display("FAIL num0_cfgrdy got=%0b exp=1", GLBCCU_CfgRdy); end
        CTRGLB_CrdAddrVld = 1; CTRGLB_CrdAddr = '0; CTRGLB_CrdRdy = 1;
        repeat (10) begin
            @(negedge clk);
            if (GLBCTR_CrdAddrRdy) rdy_seen++;
        end
        CTRGLB_CrdAddrVld = 0; CTRGLB_CrdRdy = 0;
        total++; if (rdy_seen != 0 || rd_q.size() != 0) begin
            bad++; $display("FAIL num0_quiet got=rdy%0d/reads%0d exp=0/0", rdy_seen, rd_q.size()); end
        total++; if (GLBCCU_CfgRdy !== 1'b1) begin bad++; $display("FAIL num0_idle got=%0b exp=1", GLBCCU_CfgRdy); end
    endtask

    task automatic test_random();
        for (int r = 0; r < 6; r++) begin
            logic [AW-1:0] base = AW'($urandom);
            int            num  = $urandom_range(16, 1);
            a_q_t          a = {};
            logic [SW-1:0] exp_d[$];
            logic [AW-1:0] exp_r[$];
            logic          any_oor = 0;
            int            nerr = 0;
            for (int i = 0; i < num; i++) begin
                logic [IW-1:0] x = IW'($urandom_range(num + 3, 0));
                a.push_back(x);
                if (x < num) begin
                    exp_r.push_back(AW'(base + x));
                    exp_d.push_back(mkword(AW'(base + x)));
                end else begin
                    any_oor = 1; exp_d.push_back('0);
                end
            end
            cfg(base, IW'(num)); clear_mon();
            run_stream(a, num, $urandom_range(100, 30), $urandom_range(100, 20), 2000);
            idle(4, 1'b1);
            total++; if (dat_q.size() != num || rd_q.size() != exp_r.size()) begin
                bad++; $display("FAIL rnd%0d_cnt got=%0d/%0d exp=%0d/%0d", r, dat_q.size(), rd_q.size(), num, exp_r.size()); end
            for (int i = 0; i < num; i++)
                if (i >= dat_q.size() || dat_q[i] !== exp_d[i]) nerr++;
            for (int i = 0; i < exp_r.size(); i++)
                if (i >= rd_q.size() || rd_q[i] !== exp_r[i]) nerr++;
            total++; if (nerr != 0) begin bad++; $display("FAIL rnd%0d_order got=%0d wrong exp=0", r, nerr); end
            total++; if (GLBCCU_AddrErr !== any_oor || GLBCCU_CfgRdy !== 1'b1) begin
                bad++; $display("FAIL rnd%0d_flags got=err%0b/cfgrdy%0b exp=%0b/1", r, GLBCCU_AddrErr, GLBCCU_CfgRdy, any_oor); end
        end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_wrap();
        test_out_of_range();
        test_soft_clear();
        test_num_zero();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
